// File: rtl/note_encoder.sv
// note_encoder
//   Measures the period of an 8-bit amplitude waveform (midpoint 128) by
//   counting valid samples between rising crossings with hysteresis. It then
//   converts each accepted period into a note number, note = 12*octave + semitone.
//
// Parameters
//   HYST          hysteresis half-width around 128, in LSBs (1..64)
// Ports
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   sample        unsigned amplitude sample
//   sample_valid  1 = sample consumed this cycle
//   note          encoded note 0..95, held between updates
//   note_valid    one-cycle pulse when note updates
//   no_signal     1 = no valid period since reset or last timeout
module note_encoder #(
  parameter int HYST = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sample,
  input  logic       sample_valid,
  output logic [9:0] note,
  output logic       note_valid,
  output logic       no_signal
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MEAS = 1'b1;

  localparam logic [7:0]  LO_TH   = 8'(128 - HYST);
  localparam logic [7:0]  HI_TH   = 8'(128 + HYST);
  localparam logic [11:0] CNT_TO  = 12'd4094;  // one more sample would reach 4095
  localparam logic [11:0] CNT_MIN = 12'd15;    // P = cnt+1 must be >= 16

  // Semitone boundaries on the normalised period (2048..4095).
  localparam logic [11:0] TH [0:11] = '{
    12'd3979, 12'd3756, 12'd3545, 12'd3346, 12'd3158, 12'd2981,
    12'd2814, 12'd2656, 12'd2507, 12'd2366, 12'd2233, 12'd2108
  };

  // ---------------- detector / period counter ----------------
  logic [0:0]  state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic        armed_q, armed_d;
  logic        crossing, arm_set, timeout;
  logic [11:0] p_q, p_d;
  logic        p_vld;

  assign arm_set  = sample_valid && (sample < LO_TH);
  assign crossing = sample_valid && armed_q && (sample >= HI_TH);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    armed_d = armed_q;
    p_d     = p_q;
    p_vld   = 1'b0;
    timeout = 1'b0;
    if (crossing)     armed_d = 1'b0;
    else if (arm_set) armed_d = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (crossing) begin
          state_d = S_MEAS;
          cnt_d   = '0;
        end
      end
      default: begin
        if (crossing) begin
          // A crossing wins over a timeout on the same sample.
          p_d   = cnt_q + 12'd1;
          p_vld = (cnt_q >= CNT_MIN);
          cnt_d = '0;
        end else if (sample_valid) begin
          if (cnt_q == CNT_TO) begin
            timeout = 1'b1;
            state_d = S_IDLE;
            cnt_d   = '0;
            armed_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 12'd1;
          end
        end
      end
    endcase
  end

  // ---------------- conversion pipeline ----------------
  // vld_pipe_q[0]: p_q holds an accepted period
  // vld_pipe_q[1]: oct_q/n_q hold octave and normalised period
  // vld_pipe_q[2]: nsum_q holds the final note
  logic [2:0]  vld_pipe_q;
  logic [3:0]  msb;
  logic [2:0]  shamt;
  logic [11:0] n_d, n_q;
  logic [2:0]  oct_q;
  logic [3:0]  pos;
  logic [6:0]  nraw, nsum_d, nsum_q;
  logic [9:0]  note_q;
  logic        note_valid_q, no_sig_q;

  // Highest set bit of P (4..11) sets octave and the normalising shift.
  always_comb begin
    msb = 4'd11;
    for (int i = 4; i < 12; i++) begin
      if (p_q[i]) msb = 4'(i);
    end
    shamt = 3'(4'd11 - msb);
    n_d   = p_q << shamt;
  end

  // Counting all twelve thresholds yields pos = 12 when N < T11, which is
  // exactly the wrap into octave+1, pos 0. Octave 7 then gives 96 -> clamp to 95.
  always_comb begin
    pos = '0;
    for (int k = 0; k < 12; k++) begin
      if (n_q < TH[k]) pos = pos + 4'd1;
    end
    nraw   = 7'(oct_q) * 7'd12 + 7'(pos);
    nsum_d = (nraw > 7'd95) ? 7'd95 : nraw;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      armed_q      <= 1'b0;
      p_q          <= '0;
      n_q          <= '0;
      oct_q        <= '0;
      nsum_q       <= '0;
      vld_pipe_q   <= '0;
      note_q       <= '0;
      note_valid_q <= 1'b0;
      no_sig_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      armed_q    <= armed_d;
      vld_pipe_q <= {vld_pipe_q[1:0], p_vld};
      if (p_vld)         p_q    <= p_d;
      if (vld_pipe_q[0]) begin
        n_q   <= n_d;
        oct_q <= shamt;
      end
      if (vld_pipe_q[1]) nsum_q <= nsum_d;
      if (vld_pipe_q[2]) note_q <= 10'(nsum_q);
      note_valid_q <= vld_pipe_q[2];
      if (timeout)            no_sig_q <= 1'b1;
      else if (vld_pipe_q[2]) no_sig_q <= 1'b0;
    end
  end

  assign note       = note_q;
  assign note_valid = note_valid_q;
  assign no_signal  = no_sig_q;

endmodule

// File: tb/tb_note_encoder.sv
// Directed bench for note_encoder (HYST = 8). Waves are built from high (200)
// and low (50) runs; a period of P valid samples starts at a crossing sample.
module tb_note_encoder;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sample = '0;
  logic       sample_valid = 1'b0;
  logic [9:0] note;
  logic       note_valid, no_signal;

  int checks = 0;
  int errors = 0;

  logic       nv_obs   [0:4];
  logic       ns_obs   [0:4];
  logic [9:0] note_obs [0:4];

  always #5 clk = ~clk;

  note_encoder #(.HYST(8)) dut (
    .clk(clk), .rst(rst), .sample(sample), .sample_valid(sample_valid),
    .note(note), .note_valid(note_valid), .no_signal(no_signal)
  );

  task automatic drive(input logic [7:0] s, input logic v);
    sample = s;
    sample_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [7:0] s, input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      drive(s, 1'b1);
      if (gap) drive(8'd0, 1'b0);
    end
  endtask

  // Remaining p-done valid samples of a period: high half then low half.
  task automatic body(input int p, input int done, input bit gap, input bit noise);
    int rem, h;
    logic [7:0] v;
    rem = p - done;
    h = rem / 2;
    for (int i = 0; i < rem; i++) begin
      v = (i < h) ? 8'd200 : 8'd50;
      if (noise && (i % 2 == 1)) v = (i % 4 == 1) ? 8'd124 : 8'd132;
      drive(v, 1'b1);
      if (gap) drive(8'd0, 1'b0);
    end
  endtask

  // Crossing sample then four more edges; records outputs after each edge.
  // Contributes 5 valid samples (3 with gaps) to the following period.
  task automatic close_period(input bit gap);
    drive(8'd200, 1'b1);
    nv_obs[0] = note_valid; ns_obs[0] = no_signal; note_obs[0] = note;
    for (int i = 1; i <= 4; i++) begin
      if (gap && (i % 2 == 1)) drive(8'd0, 1'b0);
      else drive(8'd200, 1'b1);
      nv_obs[i] = note_valid; ns_obs[i] = no_signal; note_obs[i] = note;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive((i % 2 == 0) ? 8'd50 : 8'd200, 1'b1);
      checks++;
      if (note !== 10'd0 || note_valid !== 1'b0 || no_signal !== 1'b1) begin
        errors++;
        $display("FAIL reset_state[%0d]: note=%0d nv=%b ns=%b, expected 0/0/1", i, note, note_valid, no_signal);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_square20;
    run(8'd50, 4, 1'b0);
    close_period(1'b0);
    for (int i = 0; i <= 4; i++) begin
      checks++;
      if (nv_obs[i] !== 1'b0) begin
        errors++;
        $display("FAIL first_crossing_nv[%0d]: got %b expected 0", i, nv_obs[i]);
      end
    end
    for (int r = 0; r < 2; r++) begin
      body(20, 5, 1'b0, 1'b0);
      close_period(1'b0);
      for (int i = 0; i <= 4; i++) begin
        checks++;
        if (nv_obs[i] !== (i == 3)) begin
          errors++;
          $display("FAIL sq20_nv_timing r%0d[%0d]: got %b expected %b", r, i, nv_obs[i], (i == 3));
        end
      end
      checks++;
      if (note_obs[3] !== 10'd92) begin
        errors++;
        $display("FAIL sq20_note r%0d: got %0d expected 92", r, note_obs[3]);
      end
    end
    checks++;
    if (note_obs[2] !== 10'd92) begin
      errors++;
      $display("FAIL sq20_note_held: got %0d expected 92", note_obs[2]);
    end
  endtask

  task automatic test_no_signal_clear;
    // Fresh start so the first note's effect on no_signal is visible.
    rst = 1'b1; drive(8'd50, 1'b1); rst = 1'b0;
    run(8'd50, 4, 1'b0);
    close_period(1'b0);
    body(20, 5, 1'b0, 1'b0);
    close_period(1'b0);
    checks++;
    if (ns_obs[2] !== 1'b1 || ns_obs[3] !== 1'b0) begin
      errors++;
      $display("FAIL no_signal_clear: got %b->%b expected 1->0", ns_obs[2], ns_obs[3]);
    end
  endtask

  task automatic test_boundaries;
    int plist [0:3];
    int nlist [0:3];
    plist = '{4095, 2048, 16, 15};
    nlist = '{0, 12, 95, 95};
    for (int j = 0; j < 4; j++) begin
      body(plist[j], 5, 1'b0, 1'b0);
      close_period(1'b0);
      checks++;
      if (nv_obs[3] !== (plist[j] != 15)) begin
        errors++;
        $display("FAIL bound_nv P=%0d: got %b expected %b", plist[j], nv_obs[3], (plist[j] != 15));
      end
      checks++;
      if (note_obs[4] !== 10'(nlist[j])) begin
        errors++;
        $display("FAIL bound_note P=%0d: got %0d expected %0d", plist[j], note_obs[4], nlist[j]);
      end
    end
    for (int i = 0; i <= 4; i++) begin
      checks++;
      if (nv_obs[i] !== 1'b0) begin
        errors++;
        $display("FAIL p15_no_pulse[%0d]: got %b expected 0", i, nv_obs[i]);
      end
    end
  endtask

  task automatic test_timeout;
    body(20, 5, 1'b0, 1'b0);
    close_period(1'b0);
    checks++;
    if (note_obs[3] !== 10'd92) begin
      errors++;
      $display("FAIL pre_timeout_note: got %0d expected 92", note_obs[3]);
    end
    // Counter is 4 here; 4090 more samples bring it to 4094.
    run(8'd128, 4090, 1'b0);
    checks++;
    if (no_signal !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: no_signal=%b expected 0", no_signal);
    end
    drive(8'd128, 1'b1);
    checks++;
    if (no_signal !== 1'b1 || note !== 10'd92 || note_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout: ns=%b note=%0d nv=%b expected 1/92/0", no_signal, note, note_valid);
    end
    // Back in IDLE: the next crossing only starts a measurement.
    run(8'd50, 4, 1'b0);
    close_period(1'b0);
    for (int i = 0; i <= 4; i++) begin
      checks++;
      if (nv_obs[i] !== 1'b0) begin
        errors++;
        $display("FAIL post_timeout_idle[%0d]: got %b expected 0", i, nv_obs[i]);
      end
    end
    body(20, 5, 1'b0, 1'b0);
    close_period(1'b0);
    checks++;
    if (nv_obs[3] !== 1'b1 || note_obs[3] !== 10'd92 || ns_obs[3] !== 1'b0) begin
      errors++;
      $display("FAIL post_timeout_note: nv=%b note=%0d ns=%b expected 1/92/0", nv_obs[3], note_obs[3], ns_obs[3]);
    end
  endtask

  task automatic test_noise;
    for (int r = 0; r < 2; r++) begin
      body(20, 5, 1'b0, 1'b1);
      close_period(1'b0);
      checks++;
      if (nv_obs[3] !== 1'b1 || note_obs[3] !== 10'd92 || nv_obs[2] !== 1'b0 || nv_obs[4] !== 1'b0) begin
        errors++;
        $display("FAIL noise r%0d: nv=%b note=%0d expected 1/92", r, nv_obs[3], note_obs[3]);
      end
    end
  endtask

  task automatic test_valid_gaps;
    for (int r = 0; r < 2; r++) begin
      body(20, (r == 0) ? 5 : 3, 1'b1, 1'b0);
      close_period(1'b1);
      for (int i = 0; i <= 4; i++) begin
        checks++;
        if (nv_obs[i] !== (i == 3)) begin
          errors++;
          $display("FAIL gaps_nv r%0d[%0d]: got %b expected %b", r, i, nv_obs[i], (i == 3));
        end
      end
      checks++;
      if (note_obs[3] !== 10'd92) begin
        errors++;
        $display("FAIL gaps_note r%0d: got %0d expected 92", r, note_obs[3]);
      end
    end
  endtask

  task automatic test_reset_mid;
    body(20, 3, 1'b0, 1'b0);
    drive(8'd200, 1'b1);          // period-ending crossing
    rst = 1'b1;
    drive(8'd200, 1'b1);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(8'd200, 1'b1);
      checks++;
      if (note_valid !== 1'b0 || note !== 10'd0 || no_signal !== 1'b1) begin
        errors++;
        $display("FAIL reset_mid[%0d]: nv=%b note=%0d ns=%b expected 0/0/1", i, note_valid, note, no_signal);
      end
    end
    run(8'd50, 4, 1'b0);
    close_period(1'b0);
    checks++;
    if (nv_obs[3] !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_first: nv=%b expected 0", nv_obs[3]);
    end
    body(20, 5, 1'b0, 1'b0);
    close_period(1'b0);
    checks++;
    if (nv_obs[3] !== 1'b1 || note_obs[3] !== 10'd92 || ns_obs[3] !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_recover: nv=%b note=%0d ns=%b expected 1/92/0", nv_obs[3], note_obs[3], ns_obs[3]);
    end
  endtask

  initial begin
    test_reset();
    test_square20();
    test_boundaries();
    test_no_signal_clear();
    test_timeout();
    test_noise();
    test_valid_gaps();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
